bullcow_match: RTL and testbench
================================

Name: bullcow_match

Overview:
Parametrised two-player Bulls-and-Cows match engine.
- Each player enters a secret code of NDIG distinct base-BASE digits; players then alternate guesses against the opponent's secret.
- The block registers each bulls/cows result and keeps saturating per-player win counters across rounds.
- Sits between the switch/button input conditioning and the display/LED driver of the game top level.
- Adds over the first-generation game: edge-detected enter handshake, attempt limit with draw, alternating first guesser, and a digit range check.

Parameters:
NDIG, 4, digits per code (2..8)
DW, 4, bits per digit
BASE, 10, digit value must be < BASE (BASE <= 2**DW)
PTS_W, 8, width of each win counter
MAX_TRIES, 10, guesses allowed per player per round; 0 = unlimited

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
enter  in  1  level from debounced button; the engine acts on its rising edge only
code_in  in  NDIG*DW  digit k is code_in[k*DW +: DW]
phase  out  3  current state encoding (phase_t)
turn  out  1  player whose input is expected (0 = J1, 1 = J2)
bulls  out  $clog2(NDIG+1)  bulls of the last scored guess
cows  out  $clog2(NDIG+1)  cows of the last scored guess
result_valid  out  1  one-cycle pulse when bulls/cows update
input_err  out  1  one-cycle pulse on a rejected entry
tries  out  $clog2(MAX_TRIES+2)  guesses made by the current guesser this round
winner  out  2  00 none, 01 J1, 10 J2, 11 draw; valid in END_GAME
points  out  2*PTS_W  [PTS_W-1:0] = J1 wins, [2*PTS_W-1:PTS_W] = J2 wins

Behaviour:
Reset (synchronous, active-high):
- phase = SETUP1, turn = 0, all outputs 0, secrets cleared, starter = J1.
- Reset asserted mid-round abandons the round; points also clear.

Enter handshake:
- enter_q is a register; ev = enter & ~enter_q.
- A held enter produces exactly one ev.
- code_in is sampled in the ev cycle only.

Validity:
- Entry is valid iff every digit < BASE and all NDIG digits are pairwise distinct.
- Invalid entry: input_err pulses the cycle after ev; the state is unchanged; secrets and tries are unchanged.

States (phase_t):
- SETUP1(0): valid ev stores secret1 -> SETUP2.
- SETUP2(1): valid ev stores secret2 -> GUESS; turn = starter.
- GUESS(2): valid ev registers the guess -> SCORE.
- SCORE(3): exactly one cycle.
  - bulls = count of i with g[i]==s[i]; cows = count of i != j with g[i]==s[j]; s is the opponent's secret.
  - result_valid = 1 this cycle; the guesser's tries increment.
  - Latency from ev to result_valid is 2 cycles.
- Exit from SCORE:
  - bulls == NDIG: winner = guesser; that player's points +1, saturating at 2**PTS_W-1 -> END_GAME.
  - Otherwise, if MAX_TRIES != 0 and both players' tries == MAX_TRIES: winner = 11, no points -> END_GAME.
  - Otherwise turn toggles -> GUESS.
- END_GAME(7): bulls, cows and winner hold. ev (code_in ignored, never an error) causes:
  - starter toggles;
  - secrets and tries clear, winner = 00;
  - -> SETUP1.
- Unused encodings -> SETUP1.

Displayed tries:
- tries shows the count for the player indicated by turn.
- bulls and cows hold their value until the next SCORE.

Decomposition:
- Package bullcow_pkg holds:
  - phase_t enum;
  - winner codes (WIN_NONE, WIN_J1, WIN_J2, WIN_DRAW);
  - a function code_valid(code, NDIG, DW, BASE).
- One sub-module, bullcow_scorer: combinational, parametrised NDIG/DW, takes guess and secret, outputs bulls and cows.
  - It is instantiated once; its outputs are registered in SCORE.

Test Plan (NDIG=4, DW=4, BASE=10, MAX_TRIES=2; codes written digit3..digit0):
- Reset, then secrets J1=1234 and J2=5678, each with one enter press held 5 cycles -> phase reaches GUESS after exactly 2 ev; turn=0; no input_err.
- In SETUP1, enter 1123, then 12A4 -> input_err pulses twice; phase stays SETUP1.
- J1 guesses 8765 against 5678 -> 2 cycles after ev: bulls=0, cows=4, result_valid=1 for one cycle; turn=1.
- J2 guesses 1243 against 1234 -> bulls=2, cows=2. J1 then guesses 5678 -> bulls=4, winner=01, points[7:0]=1, phase=END_GAME.
- From END_GAME: ev -> SETUP1. After new secrets, turn=1 (J2 starts). Four non-winning guesses -> winner=11; both point fields unchanged.
- Preload J1 points to 255 and win again -> points[7:0] stays 255. Assert reset during GUESS -> next cycle phase=SETUP1 and points=0.

Source files
------------

// File: rtl/bullcow_pkg.sv
// Shared types and helpers for the Bulls-and-Cows match engine.
package bullcow_pkg;

    typedef enum logic [2:0] {
        SETUP1   = 3'd0,
        SETUP2   = 3'd1,
        GUESS    = 3'd2,
        SCORE    = 3'd3,
        END_GAME = 3'd7
    } phase_t;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_J1   = 2'b01;
    localparam logic [1:0] WIN_J2   = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    // Widest code the validity helper accepts (8 digits of 8 bits).
    localparam int CODE_MAX_W = 64;

    // True when every digit is below base and no two digits repeat.
    function automatic logic code_valid(input logic [CODE_MAX_W-1:0] code,
                                        input int ndig, input int dw,
                                        input int base);
        logic                  ok;
        logic [CODE_MAX_W-1:0] mask;
        logic [CODE_MAX_W-1:0] di;
        logic [CODE_MAX_W-1:0] dj;
        ok   = 1'b1;
        mask = (CODE_MAX_W'(1) << dw) - CODE_MAX_W'(1);
        for (int i = 0; i < ndig; i++) begin
            di = (code >> (i * dw)) & mask;
            if (di >= CODE_MAX_W'(base)) ok = 1'b0;
            for (int j = i + 1; j < ndig; j++) begin
                dj = (code >> (j * dw)) & mask;
                if (di == dj) ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/bullcow_match_if.sv
// Button/code inputs and status outputs of the match engine.
interface bullcow_match_if #(
    parameter int NDIG      = 4,
    parameter int DW        = 4,
    parameter int PTS_W     = 8,
    parameter int MAX_TRIES = 10
);
    import bullcow_pkg::*;

    localparam int CW = $clog2(NDIG + 1);
    localparam int TW = $clog2(MAX_TRIES + 2);

    logic                 enter;
    logic [NDIG*DW-1:0]   code_in;
    phase_t               phase;
    logic                 turn;
    logic [CW-1:0]        bulls;
    logic [CW-1:0]        cows;
    logic                 result_valid;
    logic                 input_err;
    logic [TW-1:0]        tries;
    logic [1:0]           winner;
    logic [2*PTS_W-1:0]   points;

    modport master (
        output enter, code_in,
        input  phase, turn, bulls, cows, result_valid, input_err, tries, winner, points
    );

    modport slave (
        input  enter, code_in,
        output phase, turn, bulls, cows, result_valid, input_err, tries, winner, points
    );

endinterface

// File: rtl/bullcow_scorer.sv
// Combinational bulls/cows count of a guess against a secret.
module bullcow_scorer #(
    parameter int NDIG = 4,
    parameter int DW   = 4
) (
    input  logic [NDIG*DW-1:0]          guess,
    input  logic [NDIG*DW-1:0]          secret,
    output logic [$clog2(NDIG+1)-1:0]   bulls,
    output logic [$clog2(NDIG+1)-1:0]   cows
);
    localparam int CW = $clog2(NDIG + 1);

    // Every digit pair: same position is a bull, different position a cow.
    always_comb begin
        bulls = '0;
        cows  = '0;
        for (int i = 0; i < NDIG; i++) begin
            for (int j = 0; j < NDIG; j++) begin
                if (guess[i*DW +: DW] == secret[j*DW +: DW]) begin
                    if (i == j) bulls = bulls + CW'(1);
                    else        cows  = cows + CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/bullcow_match.sv
// Two-player Bulls-and-Cows match engine: secret entry, alternating
// guesses, attempt limit with draw, and saturating win counters.
module bullcow_match
    import bullcow_pkg::*;
#(
    parameter int NDIG      = 4,
    parameter int DW        = 4,
    parameter int BASE      = 10,
    parameter int PTS_W     = 8,
    parameter int MAX_TRIES = 10
) (
    input  logic           clock,
    input  logic           reset,
    bullcow_match_if.slave bus
);
    localparam int CW     = $clog2(NDIG + 1);
    localparam int TW     = $clog2(MAX_TRIES + 2);
    localparam int CODE_W = NDIG * DW;

    localparam logic [CW-1:0]    FULL_BULLS = CW'(NDIG);
    localparam logic [TW-1:0]    TRY_LIM    = TW'(MAX_TRIES);
    localparam logic [TW-1:0]    TRY_SAT    = '1;
    localparam logic [PTS_W-1:0] PTS_SAT    = '1;

    phase_t              state_q, state_d;
    logic                enter_q, enter_d;
    logic                turn_q, turn_d;
    logic                starter_q, starter_d;
    logic [CODE_W-1:0]   secret1_q, secret1_d;
    logic [CODE_W-1:0]   secret2_q, secret2_d;
    logic [CODE_W-1:0]   guess_q, guess_d;
    logic [CW-1:0]       bulls_q, bulls_d;
    logic [CW-1:0]       cows_q, cows_d;
    logic                rv_q, rv_d;
    logic                err_q, err_d;
    logic [TW-1:0]       tries1_q, tries1_d;
    logic [TW-1:0]       tries2_q, tries2_d;
    logic [1:0]          winner_q, winner_d;
    logic [PTS_W-1:0]    pts1_q, pts1_d;
    logic [PTS_W-1:0]    pts2_q, pts2_d;

    logic                ev;
    logic                entry_ok;
    logic [CW-1:0]       sc_bulls;
    logic [CW-1:0]       sc_cows;

    assign ev       = bus.enter & ~enter_q;
    assign entry_ok = code_valid(CODE_MAX_W'(bus.code_in), NDIG, DW, BASE);

    // The guesser is always scored against the opponent's secret.
    bullcow_scorer #(.NDIG(NDIG), .DW(DW)) u_scorer (
        .guess  (guess_q),
        .secret (turn_q ? secret1_q : secret2_q),
        .bulls  (sc_bulls),
        .cows   (sc_cows)
    );

    // Next-state and next-output logic for the match sequence.
    always_comb begin
        state_d   = state_q;
        enter_d   = bus.enter;
        turn_d    = turn_q;
        starter_d = starter_q;
        secret1_d = secret1_q;
        secret2_d = secret2_q;
        guess_d   = guess_q;
        bulls_d   = bulls_q;
        cows_d    = cows_q;
        rv_d      = 1'b0;
        err_d     = 1'b0;
        tries1_d  = tries1_q;
        tries2_d  = tries2_q;
        winner_d  = winner_q;
        pts1_d    = pts1_q;
        pts2_d    = pts2_q;

        case (state_q)
            SETUP1: begin
                if (ev) begin
                    if (entry_ok) begin
                        secret1_d = bus.code_in;
                        turn_d    = 1'b1;
                        state_d   = SETUP2;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            SETUP2: begin
                if (ev) begin
                    if (entry_ok) begin
                        secret2_d = bus.code_in;
                        turn_d    = starter_q;
                        state_d   = GUESS;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            GUESS: begin
                if (ev) begin
                    if (entry_ok) begin
                        guess_d = bus.code_in;
                        state_d = SCORE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            SCORE: begin
                bulls_d = sc_bulls;
                cows_d  = sc_cows;
                rv_d    = 1'b1;
                if (turn_q) begin
                    if (tries2_q != TRY_SAT) tries2_d = tries2_q + TW'(1);
                end else begin
                    if (tries1_q != TRY_SAT) tries1_d = tries1_q + TW'(1);
                end
                if (sc_bulls == FULL_BULLS) begin
                    state_d = END_GAME;
                    if (turn_q) begin
                        winner_d = WIN_J2;
                        if (pts2_q != PTS_SAT) pts2_d = pts2_q + PTS_W'(1);
                    end else begin
                        winner_d = WIN_J1;
                        if (pts1_q != PTS_SAT) pts1_d = pts1_q + PTS_W'(1);
                    end
                end else if ((MAX_TRIES != 0) && (tries1_d == TRY_LIM) &&
                             (tries2_d == TRY_LIM)) begin
                    winner_d = WIN_DRAW;
                    state_d  = END_GAME;
                end else begin
                    turn_d  = ~turn_q;
                    state_d = GUESS;
                end
            end
            END_GAME: begin
                // code_in is ignored here; any press starts the next round.
                if (ev) begin
                    starter_d = ~starter_q;
                    secret1_d = '0;
                    secret2_d = '0;
                    tries1_d  = '0;
                    tries2_d  = '0;
                    winner_d  = WIN_NONE;
                    turn_d    = 1'b0;
                    state_d   = SETUP1;
                end
            end
            default: begin
                state_d = SETUP1;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= SETUP1;
            enter_q   <= 1'b0;
            turn_q    <= 1'b0;
            starter_q <= 1'b0;
            secret1_q <= '0;
            secret2_q <= '0;
            guess_q   <= '0;
            bulls_q   <= '0;
            cows_q    <= '0;
            rv_q      <= 1'b0;
            err_q     <= 1'b0;
            tries1_q  <= '0;
            tries2_q  <= '0;
            winner_q  <= WIN_NONE;
            pts1_q    <= '0;
            pts2_q    <= '0;
        end else begin
            state_q   <= state_d;
            enter_q   <= enter_d;
            turn_q    <= turn_d;
            starter_q <= starter_d;
            secret1_q <= secret1_d;
            secret2_q <= secret2_d;
            guess_q   <= guess_d;
            bulls_q   <= bulls_d;
            cows_q    <= cows_d;
            rv_q      <= rv_d;
            err_q     <= err_d;
            tries1_q  <= tries1_d;
            tries2_q  <= tries2_d;
            winner_q  <= winner_d;
            pts1_q    <= pts1_d;
            pts2_q    <= pts2_d;
        end
    end

    assign bus.phase        = state_q;
    assign bus.turn         = turn_q;
    assign bus.bulls        = bulls_q;
    assign bus.cows         = cows_q;
    assign bus.result_valid = rv_q;
    assign bus.input_err    = err_q;
    assign bus.tries        = turn_q ? tries2_q : tries1_q;
    assign bus.winner       = winner_q;
    assign bus.points       = {pts2_q, pts1_q};

endmodule

// File: tb/tb_bullcow_match.sv
// Testbench for bullcow_match: directed match scenarios plus randomized
// rounds, checked against a game-rules reference model.
module tb_bullcow_match;
    import bullcow_pkg::*;

    localparam int NDIG      = 4;
    localparam int DW        = 4;
    localparam int BASE      = 10;
    localparam int PTS_W     = 8;
    localparam int MAX_TRIES = 2;
    localparam int PTS_MAX   = 255;

    localparam logic [2:0] P_S1  = 3'd0;
    localparam logic [2:0] P_S2  = 3'd1;
    localparam logic [2:0] P_G   = 3'd2;
    localparam logic [2:0] P_SC  = 3'd3;
    localparam logic [2:0] P_END = 3'd7;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    bullcow_match_if #(.NDIG(NDIG), .DW(DW), .PTS_W(PTS_W), .MAX_TRIES(MAX_TRIES)) bus ();

    bullcow_match #(
        .NDIG(NDIG), .DW(DW), .BASE(BASE), .PTS_W(PTS_W), .MAX_TRIES(MAX_TRIES)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // reference model of the game
    logic [2:0]  m_phase;
    bit          m_turn;
    bit          m_starter;
    logic [15:0] m_sec[2];
    int          m_tries[2];
    int          m_bulls;
    int          m_cows;
    logic [1:0]  m_winner;
    int          m_pts[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    function automatic bit ref_valid(input logic [15:0] c);
        bit seen[16];
        int d;
        for (int v = 0; v < 16; v++) seen[v] = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            d = int'(c[i*DW +: DW]);
            if (d >= BASE) return 1'b0;
            if (seen[d]) return 1'b0;
            seen[d] = 1'b1;
        end
        return 1'b1;
    endfunction

    // bulls by position; cows = shared digit values minus bulls
    task automatic ref_score(input logic [15:0] g, input logic [15:0] s,
                             output int b, output int c);
        int cg[16];
        int cs[16];
        int common;
        for (int v = 0; v < 16; v++) begin
            cg[v] = 0;
            cs[v] = 0;
        end
        b = 0;
        common = 0;
        for (int i = 0; i < NDIG; i++) begin
            if (g[i*DW +: DW] == s[i*DW +: DW]) b++;
            cg[int'(g[i*DW +: DW])]++;
            cs[int'(s[i*DW +: DW])]++;
        end
        for (int v = 0; v < 16; v++) common += (cg[v] < cs[v]) ? cg[v] : cs[v];
        c = common - b;
    endtask

    function automatic logic [15:0] rand_code();
        int pool[10];
        int k;
        int t;
        logic [15:0] c;
        for (int i = 0; i < 10; i++) pool[i] = i;
        c = '0;
        for (int i = 0; i < NDIG; i++) begin
            k = int'($urandom_range(i, 9));
            t = pool[i];
            pool[i] = pool[k];
            pool[k] = t;
            c[i*DW +: DW] = 4'(pool[i]);
        end
        return c;
    endfunction

    function automatic logic [15:0] nonwin(input logic [15:0] s);
        logic [15:0] g;
        g = rand_code();
        if (g == s) g = {g[11:0], g[15:12]};
        return g;
    endfunction

    task automatic model_reset();
        m_phase   = P_S1;
        m_turn    = 1'b0;
        m_starter = 1'b0;
        m_sec[0]  = '0;
        m_sec[1]  = '0;
        m_tries[0] = 0;
        m_tries[1] = 0;
        m_bulls   = 0;
        m_cows    = 0;
        m_winner  = 2'b00;
        m_pts[0]  = 0;
        m_pts[1]  = 0;
    endtask

    // One button press with the enter level held for 'hold' cycles.
    task automatic entry(input logic [15:0] code, input int hold);
        bit exp_err;
        bit scored;
        bit ok;
        logic [2:0] mid_phase;
        int last;
        exp_err = 1'b0;
        scored  = 1'b0;
        ok = ref_valid(code);
        case (m_phase)
            P_S1: begin
                if (ok) begin m_sec[0] = code; m_phase = P_S2; end
                else exp_err = 1'b1;
            end
            P_S2: begin
                if (ok) begin m_sec[1] = code; m_phase = P_G; m_turn = m_starter; end
                else exp_err = 1'b1;
            end
            P_G: begin
                if (ok) begin
                    scored = 1'b1;
                    ref_score(code, m_sec[m_turn ? 0 : 1], m_bulls, m_cows);
                    m_tries[m_turn]++;
                    if (m_bulls == NDIG) begin
                        m_winner = m_turn ? 2'b10 : 2'b01;
                        if (m_pts[m_turn] < PTS_MAX) m_pts[m_turn]++;
                        m_phase = P_END;
                    end else if (m_tries[0] == MAX_TRIES && m_tries[1] == MAX_TRIES) begin
                        m_winner = 2'b11;
                        m_phase = P_END;
                    end else begin
                        m_turn = !m_turn;
                    end
                end else begin
                    exp_err = 1'b1;
                end
            end
            default: begin
                m_starter  = !m_starter;
                m_sec[0]   = '0;
                m_sec[1]   = '0;
                m_tries[0] = 0;
                m_tries[1] = 0;
                m_winner   = 2'b00;
                m_phase    = P_S1;
            end
        endcase
        mid_phase = scored ? P_SC : m_phase;
        last = (hold > 3) ? hold : 3;

        bus.enter   = 1'b1;
        bus.code_in = code;
        for (int k = 1; k <= last; k++) begin
            cyc();
            bus.code_in = 16'($urandom);
            if (k == hold) bus.enter = 1'b0;
            if (k == 1) begin
                chk("input_err_after_ev", 32'(bus.input_err), 32'(exp_err));
                chk("phase_after_ev", 32'(bus.phase), 32'(mid_phase));
            end else if (k == 2) begin
                chk("result_valid", 32'(bus.result_valid), 32'(scored));
                chk("phase", 32'(bus.phase), 32'(m_phase));
                chk("bulls", 32'(bus.bulls), 32'(m_bulls));
                chk("cows", 32'(bus.cows), 32'(m_cows));
                chk("winner", 32'(bus.winner), 32'(m_winner));
                chk("points", 32'(bus.points), 32'(m_pts[1] * 256 + m_pts[0]));
                if (m_phase == P_G || m_phase == P_END) begin
                    chk("turn", 32'(bus.turn), 32'(m_turn));
                    chk("tries", 32'(bus.tries), 32'(m_tries[m_turn]));
                end
            end else begin
                chk("result_valid_pulse", 32'(bus.result_valid), 32'd0);
                chk("input_err_pulse", 32'(bus.input_err), 32'd0);
                chk("phase_held_enter", 32'(bus.phase), 32'(m_phase));
            end
        end
        cyc();
    endtask

    // From END_GAME: new secrets, J1 ends up winning the round.
    task automatic round_j1_wins();
        entry(16'($urandom), 1);
        if ($urandom_range(0, 3) == 0) entry(16'($urandom), 1);
        while (m_phase == P_S1) entry(rand_code(), 1);
        while (m_phase == P_S2) entry(rand_code(), 1);
        if (m_turn) entry(nonwin(m_sec[0]), 1);
        entry(m_sec[1], 1);
    endtask

    initial begin
        reset       = 1'b1;
        bus.enter   = 1'b0;
        bus.code_in = '0;
        model_reset();
        cyc();
        cyc();
        chk("rst_phase", 32'(bus.phase), 32'(P_S1));
        chk("rst_turn", 32'(bus.turn), 32'd0);
        chk("rst_bulls", 32'(bus.bulls), 32'd0);
        chk("rst_cows", 32'(bus.cows), 32'd0);
        chk("rst_result_valid", 32'(bus.result_valid), 32'd0);
        chk("rst_input_err", 32'(bus.input_err), 32'd0);
        chk("rst_tries", 32'(bus.tries), 32'd0);
        chk("rst_winner", 32'(bus.winner), 32'd0);
        chk("rst_points", 32'(bus.points), 32'd0);
        reset = 1'b0;
        cyc();

        // invalid setup entries: repeated digit, digit out of range
        entry(16'h1123, 1);
        entry(16'h12A4, 1);
        chk("setup_still_s1", 32'(bus.phase), 32'(P_S1));

        // secrets with a held press each
        entry(16'h1234, 5);
        entry(16'h5678, 5);
        chk("guess_reached", 32'(bus.phase), 32'(P_G));
        chk("guess_turn_j1", 32'(bus.turn), 32'd0);

        entry(16'h8765, 1);
        entry(16'h1243, 1);
        entry(16'h5678, 1);
        chk("j1_win_points", 32'(bus.points[7:0]), 32'd1);
        chk("j1_win_phase", 32'(bus.phase), 32'(P_END));

        // second round: J2 starts, draw after four misses
        entry(16'h1123, 1);
        entry(rand_code(), 1);
        entry(rand_code(), 1);
        chk("round2_turn_j2", 32'(bus.turn), 32'd1);
        entry(nonwin(m_sec[0]), 1);
        entry(16'h99AB, 1);
        entry(nonwin(m_sec[1]), 1);
        entry(nonwin(m_sec[0]), 1);
        entry(nonwin(m_sec[1]), 1);
        chk("draw_winner", 32'(bus.winner), 32'd3);
        chk("draw_points", 32'(bus.points), 32'h0001);

        // drive J1 to saturation, then win once more
        for (int r = 0; r < 400 && m_pts[0] < PTS_MAX; r++) round_j1_wins();
        chk("j1_points_255", 32'(bus.points[7:0]), 32'd255);
        round_j1_wins();
        chk("j1_points_sat", 32'(bus.points[7:0]), 32'd255);

        // reset in the middle of a round
        entry(16'h0000, 1);
        entry(rand_code(), 1);
        entry(rand_code(), 1);
        chk("pre_reset_guess", 32'(bus.phase), 32'(P_G));
        reset = 1'b1;
        cyc();
        chk("mid_reset_phase", 32'(bus.phase), 32'(P_S1));
        chk("mid_reset_points", 32'(bus.points), 32'd0);
        reset = 1'b0;
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
